// File: rtl/dds_pkg.sv
// Shared types and helpers for the multi-channel DDS engine.
// Build option DDS_PHASE_OFFSET_EN is consumed by dds_phase_bank and dds_multi_channel.
package dds_pkg;

   typedef enum logic [1:0] {
      DDS_MODE_RAM   = 2'b00,
      DDS_MODE_SAW   = 2'b01,
      DDS_MODE_CONST = 2'b10,
      DDS_MODE_OFF   = 2'b11
   } dds_mode_e;

   function automatic logic [31:0] dds_midscale(input int unsigned width);
      return 32'd1 << (width - 1);
   endfunction

   // Low bit of channel k's slice in a bus packed k*width upwards
   function automatic int unsigned dds_slice_lo(input int unsigned k, input int unsigned width);
      return k * width;
   endfunction

   // Channel-index width; never narrower than one bit
   function automatic int unsigned dds_ch_w(input int unsigned channels);
      return (channels > 1) ? $clog2(channels) : 1;
   endfunction

endpackage

// File: rtl/dds_multi_channel_if.sv
// Waveform-RAM read port of the DDS engine: the engine is master, the RAM is slave.
interface dds_multi_channel_if #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 12,
   parameter int unsigned CH_W   = 1
);
   logic [ADDR_W-1:0] ram_addr;
   logic [CH_W-1:0]   ram_ch;
   logic [DATA_W-1:0] ram_data;

   modport master (output ram_addr, output ram_ch, input ram_data);
   modport slave  (input ram_addr, input ram_ch, output ram_data);
endinterface

// File: rtl/dds_phase_bank.sv
// Per-channel phase accumulators, serviced one slot at a time.
// With DDS_PHASE_OFFSET_EN a per-channel offset is added to the output phase only.
module dds_phase_bank
   import dds_pkg::*;
#(
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned DATA_W   = 12,
   parameter int unsigned ADDR_W   = 10,
   parameter int unsigned PHASE_W  = 24,
   parameter int unsigned RATE_W   = 16,
   parameter int unsigned CH_W     = 1
)(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        issue,
   input  logic                        sync_phase,
   input  logic [CH_W-1:0]             slot,
   input  logic [CHANNELS*RATE_W-1:0]  rate,
`ifdef DDS_PHASE_OFFSET_EN
   input  logic [CHANNELS*PHASE_W-1:0] phase_offset,
`endif
   output logic [ADDR_W-1:0]           addr_next,
   output logic [DATA_W-1:0]           saw_next
);

   logic [PHASE_W-1:0] acc_q [CHANNELS];
   logic [PHASE_W-1:0] acc_d [CHANNELS];
   logic [PHASE_W-1:0] acc_sel;
   logic [PHASE_W-1:0] acc_sum;
   logic [PHASE_W-1:0] phase_eff;
   logic [RATE_W-1:0]  rate_sel;
`ifdef DDS_PHASE_OFFSET_EN
   logic [PHASE_W-1:0] offset_sel;
`endif

   always_comb begin
      acc_sel  = '0;
      rate_sel = '0;
`ifdef DDS_PHASE_OFFSET_EN
      offset_sel = '0;
`endif
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         if (slot == CH_W'(k)) begin
            acc_sel  = acc_q[k];
            rate_sel = rate[dds_slice_lo(k, RATE_W) +: RATE_W];
`ifdef DDS_PHASE_OFFSET_EN
            offset_sel = phase_offset[dds_slice_lo(k, PHASE_W) +: PHASE_W];
`endif
         end
      end
      acc_sum = acc_sel + PHASE_W'(rate_sel);
`ifdef DDS_PHASE_OFFSET_EN
      phase_eff = acc_sum + offset_sel;
`else
      phase_eff = acc_sum;
`endif
      addr_next = ADDR_W'(phase_eff >> (PHASE_W - ADDR_W));
      saw_next  = DATA_W'(phase_eff >> (PHASE_W - DATA_W));
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         if (sync_phase)
            acc_d[k] = '0;
         else if (issue && slot == CH_W'(k))
            acc_d[k] = acc_sum;
         else
            acc_d[k] = acc_q[k];
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         if (reset)
            acc_q[k] <= '0;
         else
            acc_q[k] <= acc_d[k];
      end
   end

endmodule

// File: rtl/dds_multi_channel.sv
// Time-multiplexed multi-channel DDS: slot counter, 3-stage sample pipeline, output frame.
// Build option DDS_PHASE_OFFSET_EN adds the phase_offset input.
module dds_multi_channel
   import dds_pkg::*;
#(
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned DATA_W   = 12,
   parameter int unsigned ADDR_W   = 10,
   parameter int unsigned PHASE_W  = 24,
   parameter int unsigned RATE_W   = 16
)(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic                        sync_phase,
   input  logic [CHANNELS*RATE_W-1:0]  rate,
   input  logic [CHANNELS*2-1:0]       mode,
   input  logic [CHANNELS*DATA_W-1:0]  const_val,
`ifdef DDS_PHASE_OFFSET_EN
   input  logic [CHANNELS*PHASE_W-1:0] phase_offset,
`endif
   dds_multi_channel_if.master         ram,
   output logic [CHANNELS*DATA_W-1:0]  sample_data,
   output logic                        sample_valid
);

   localparam int unsigned       CH_W      = dds_ch_w(CHANNELS);
   localparam logic [CH_W-1:0]   LAST_SLOT = CH_W'(CHANNELS - 1);
   localparam logic [DATA_W-1:0] MIDSCALE  = DATA_W'(dds_midscale(DATA_W));

   logic                       issue;
   logic [CH_W-1:0]            slot_q, slot_d;
   logic [ADDR_W-1:0]          addr_next;
   logic [DATA_W-1:0]          saw_next;
   dds_mode_e                  mode_sel;
   logic [DATA_W-1:0]          const_sel;

   logic                       s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
   logic [CH_W-1:0]            s1_ch_q, s1_ch_d, s2_ch_q, s2_ch_d;
   dds_mode_e                  s1_mode_q, s1_mode_d, s2_mode_q, s2_mode_d;
   logic [DATA_W-1:0]          s1_val_q, s1_val_d, s2_val_q, s2_val_d;

   logic [ADDR_W-1:0]          ram_addr_q, ram_addr_d;
   logic [CH_W-1:0]            ram_ch_q, ram_ch_d;
   logic [CHANNELS*DATA_W-1:0] sample_data_q, sample_data_d;
   logic                       sample_valid_q, sample_valid_d;

   dds_phase_bank #(
      .CHANNELS (CHANNELS),
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .PHASE_W  (PHASE_W),
      .RATE_W   (RATE_W),
      .CH_W     (CH_W)
   ) u_phase_bank (
      .clk          (clk),
      .reset        (reset),
      .issue        (issue),
      .sync_phase   (sync_phase),
      .slot         (slot_q),
      .rate         (rate),
`ifdef DDS_PHASE_OFFSET_EN
      .phase_offset (phase_offset),
`endif
      .addr_next    (addr_next),
      .saw_next     (saw_next)
   );

   // Stage 0: slot advance, sideband capture and RAM address issue
   always_comb begin
      issue     = enable && !sync_phase;
      mode_sel  = DDS_MODE_OFF;
      const_sel = '0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         if (slot_q == CH_W'(k)) begin
            mode_sel  = dds_mode_e'(mode[dds_slice_lo(k, 2) +: 2]);
            const_sel = const_val[dds_slice_lo(k, DATA_W) +: DATA_W];
         end
      end

      if (sync_phase)
         slot_d = '0;
      else if (enable)
         slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + CH_W'(1);
      else
         slot_d = slot_q;

      s1_valid_d = issue;
      s1_ch_d    = slot_q;
      s1_mode_d  = mode_sel;
      case (mode_sel)
         DDS_MODE_SAW:   s1_val_d = saw_next;
         DDS_MODE_CONST: s1_val_d = const_sel;
         DDS_MODE_OFF:   s1_val_d = MIDSCALE;
         default:        s1_val_d = '0;
      endcase

      ram_addr_d = issue ? addr_next : ram_addr_q;
      ram_ch_d   = issue ? slot_q : ram_ch_q;

      s2_valid_d = s1_valid_q;
      s2_ch_d    = s1_ch_q;
      s2_mode_d  = s1_mode_q;
      s2_val_d   = s1_val_q;
   end

   // Stage 2: land the sample; RAM data arrives here for RAM-mode channels
   always_comb begin
      sample_data_d  = sample_data_q;
      sample_valid_d = 1'b0;
      if (s2_valid_q) begin
         for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (s2_ch_q == CH_W'(k))
               sample_data_d[dds_slice_lo(k, DATA_W) +: DATA_W] =
                  (s2_mode_q == DDS_MODE_RAM) ? ram.ram_data : s2_val_q;
         end
         sample_valid_d = (s2_ch_q == LAST_SLOT);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         slot_q         <= '0;
         s1_valid_q     <= 1'b0;
         s2_valid_q     <= 1'b0;
         ram_addr_q     <= '0;
         ram_ch_q       <= '0;
         sample_data_q  <= {CHANNELS{MIDSCALE}};
         sample_valid_q <= 1'b0;
      end else begin
         slot_q         <= slot_d;
         s1_valid_q     <= s1_valid_d;
         s2_valid_q     <= s2_valid_d;
         ram_addr_q     <= ram_addr_d;
         ram_ch_q       <= ram_ch_d;
         sample_data_q  <= sample_data_d;
         sample_valid_q <= sample_valid_d;
      end
      s1_ch_q   <= s1_ch_d;
      s1_mode_q <= s1_mode_d;
      s1_val_q  <= s1_val_d;
      s2_ch_q   <= s2_ch_d;
      s2_mode_q <= s2_mode_d;
      s2_val_q  <= s2_val_d;
   end

   assign ram.ram_addr  = ram_addr_q;
   assign ram.ram_ch    = ram_ch_q;
   assign sample_data   = sample_data_q;
   assign sample_valid  = sample_valid_q;

endmodule

// File: doc/dds_multi_channel.md
# dds_multi_channel

Parametrised multi-channel DDS waveform engine that generalises the single-channel BRAM-readback sample path feeding the AD9116 DAC pod. Per-channel phase accumulators share one time-multiplexed waveform-RAM read port. Each channel independently selects RAM playback, sawtooth, constant or off. Sits between the PS-programmed BRAM/GPIO registers and the DAC PHY (`syzygy_dac_top`), delivering one aligned sample frame per `CHANNELS` clocks.

## Interface
- `CHANNELS`, 2: channel count, ≥1.
- `DATA_W`, 12: sample width, offset binary.
- `ADDR_W`, 10: waveform RAM address width; table depth is 2^`ADDR_W`.
- `PHASE_W`, 24: accumulator width, ≥ max(`ADDR_W`, `DATA_W`, `RATE_W`).
- `RATE_W`, 16: phase increment width, zero-extended to `PHASE_W`.
- `clk` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: advance slot counter and accumulators.
- `sync_phase` in 1: one-cycle pulse; clears all accumulators.
- `rate` in `CHANNELS*RATE_W`: per-channel increment; channel k occupies bits [k*`RATE_W` +: `RATE_W`].
- `mode` in `CHANNELS*2`: per-channel mode. 00 RAM, 01 sawtooth, 10 constant, 11 off.
- `const_val` in `CHANNELS*DATA_W`: constant-mode value.
- `ram_addr` out `ADDR_W`: waveform RAM read address.
- `ram_ch` out `$clog2(CHANNELS)` (min 1): channel owning `ram_addr`.
- `ram_data` in `DATA_W`: RAM read data, valid 1 cycle after `ram_addr`.
- `sample_data` out `CHANNELS*DATA_W`: latest sample per channel, same packing as `rate`.
- `sample_valid` out 1: one-cycle pulse when channel `CHANNELS-1` lands.

## Operation
- Slot counter `slot` runs 0..`CHANNELS-1` and wraps. It advances only when `enable`=1. One channel is serviced per enabled cycle.
- **Slot k, stage 0:**
  - phase[k] ← phase[k] + rate[k], modulo 2^`PHASE_W`.
  - Registers the next phase's address = phase_next[`PHASE_W`-1 -: `ADDR_W`] onto `ram_addr`.
  - `ram_ch` ← k; mode, const_val and phase top `DATA_W` bits for k are captured into the pipeline.
- **Stage 1:** RAM access cycle. Sideband (channel, mode, value) is carried alongside.
- **Stage 2:** channel k's slice of `sample_data` is written with:
  - 00: `ram_data`.
  - 01: phase_next[`PHASE_W`-1 -: `DATA_W`].
  - 10: const_val[k].
  - 11: midscale, 1<<(`DATA_W`-1).
  - `sample_valid` pulses in the same cycle when k = `CHANNELS-1`.
- All modes use the same pipeline, so latency is identical regardless of mode. `ram_addr` is driven in every mode.
- `rate`, `mode` and `const_val` are sampled only at the channel's own slot. Changes between slots are ignored until then.
- `rate`=0 holds the phase. Accumulator wrap is silent; there is no saturation.
- `enable`=0:
  - Slot counter and accumulators hold; no new stage 0 issues.
  - In-flight stages 1–2 complete, and may pulse `sample_valid`.
  - On re-enable, servicing resumes at the held slot with no skipped channel.
- `sync_phase`=1:
  - Next edge: all accumulators ← 0 and slot ← 0, regardless of `enable`.
  - No stage 0 issues that cycle; in-flight stages complete.
  - `sync_phase` together with `reset`: `reset` wins.

## Timing
- Reset values:
  - `sample_data`: every channel midscale (`DATA_W`=12 → 12'h800).
  - `sample_valid`, `ram_addr`, `ram_ch`: 0.
  - Accumulators and slot: 0. Pipeline valid bits: 0.
- Reset mid-operation: all in-flight samples are discarded; nothing lands after reset.
- Latency: slot k edge → `ram_addr` valid at +1 → `sample_data` slice updated at +3. Throughput is one channel per cycle.
- Frame period is `CHANNELS` enabled cycles; `sample_valid` spacing equals that while `enable` is held.

## Configuration
- `DDS_PHASE_OFFSET_EN` defined:
  - Adds input `phase_offset` (`CHANNELS*PHASE_W`).
  - Sampled at slot k and added, modulo, to phase_next before address/sawtooth extraction.
  - Accumulator state itself is unaffected.
- Undefined: no port; offset is effectively 0.

## Structure
- Package `dds_pkg`:
  - Mode constants `DDS_MODE_RAM`/`SAW`/`CONST`/`OFF`.
  - Function `dds_midscale(width)`.
  - Per-slice index helper.
- Sub-module `dds_phase_bank`:
  - Accumulator array, slot-indexed read/add/write, `sync_phase` clear and optional offset add.
  - Outputs phase_next for the current slot.
- Top level holds the slot counter, the pipeline and the output register.

## Test plan
All scenarios use defaults. The RAM model returns `ram_data` = {2'b0, addr} one cycle after `ram_addr`.
- **Reset:** `reset`=1 for 3 cycles → `sample_data`=24'h800800, `sample_valid`=0, `ram_addr`=0, `ram_ch`=0.
- **Sawtooth:** ch0 mode 01, rate 16'h1000, `enable`=1.
  - ch0 slice reads 12'h001, 002, … on successive `sample_valid` pulses (every 2 cycles).
  - Wraps 12'hFFF → 12'h000 after 4096 frames.
- **RAM playback:** ch1 mode 00, rate 16'h4000.
  - `ram_addr` = 1, 2, 3… in ch1 slots with `ram_ch`=1.
  - ch1 slice = 12'h001, 002… landing 2 cycles after each address.
- **Constant/off:** ch0 const 12'h123, ch1 off → `sample_data`=24'h800123 at first pulse, with the same latency as RAM mode.
- **Enable gap:** drop `enable` after ch0 issues, hold 5 cycles, re-enable.
  - Exactly one in-flight update lands during the gap.
  - ch1 issues first on resume; no channel is skipped or repeated.
- **sync_phase:** sawtooth at 12'h3A0, pulse `sync_phase` → next ch0 sample = 12'h001. With `DDS_PHASE_OFFSET_EN` and offset 24'h800000, the next sample = 12'h801.
